// File: rtl/sid_pkg.sv
// ---------------------------------------------------------------------------
// sid_pkg
// Shared definitions for the SID audio output path.
//   gain_state_t : states of the click-free mute ramp
//   GAIN_MAX     : unity gain (gain is applied as gain/16)
//   VOICE_W      : width of one voice sample
//   MIX_W        : width of the three-voice mix (max 3*255 = 765)
//   GAIN_W       : width of the ramp gain register (holds 0..16)
//   PROD_W       : width of a mix-by-gain or mix-by-volume product
// ---------------------------------------------------------------------------
package sid_pkg;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    ACTIVE    = 2'd2,
    RAMP_DOWN = 2'd3
  } gain_state_t;

  localparam int GAIN_MAX = 16;
  localparam int VOICE_W  = 8;
  localparam int MIX_W    = 10;
  localparam int GAIN_W   = 5;
  localparam int PROD_W   = MIX_W + GAIN_W;

  // Master volume: 0 is silence, otherwise the mix is scaled by (volume+1)/16,
  // so volume 15 is unity. The result never exceeds the mix value.
  function automatic logic [MIX_W-1:0] apply_volume(input logic [MIX_W-1:0] mix,
                                                    input logic [3:0]       volume);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(mix) * PROD_W'({1'b0, volume} + 5'd1);
    if (volume == 4'd0) begin
      apply_volume = '0;
    end else begin
      apply_volume = MIX_W'(prod >> 4);
    end
  endfunction

endpackage

// File: rtl/sid_pwm_mod.sv
// ---------------------------------------------------------------------------
// sid_pwm_mod
// Free-running PWM modulator. A PWM_BITS counter sets the period; the duty
// value is latched only on the last clock of a period so every period is
// produced with a single, consistent duty.
//   clk, rst       : clock, synchronous active-high reset
//   i_duty_next    : duty to latch at the end of the current period
//   o_at_max       : combinational, high while the counter is at its maximum
//                    (the parent uses it to qualify its own period-end logic)
//   o_sample_tick  : registered pulse, high for the cycle in which counter==0
//   o_duty         : duty in force for the current period
//   o_pwm_out      : registered PWM pin, high for o_duty clocks per period
// ---------------------------------------------------------------------------
module sid_pwm_mod #(
  parameter int PWM_BITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] i_duty_next,
  output logic                o_at_max,
  output logic                o_sample_tick,
  output logic [PWM_BITS-1:0] o_duty,
  output logic                o_pwm_out
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PWM_BITS-1:0] r_count;
  logic                r_tick;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_pwm;
  logic                w_at_max;

  assign w_at_max = (r_count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_duty  <= '0;
      r_pwm   <= 1'b0;
    end else begin
      // Counter wraps naturally from CNT_MAX to 0.
      r_count <= r_count + PWM_BITS'(1);
      r_tick  <= w_at_max;
      if (w_at_max) begin
        r_duty <= i_duty_next;
      end
      // Compare uses the pre-edge counter and duty, so the output trails the
      // counter by one clock; each period still holds exactly r_duty highs.
      r_pwm <= (r_count < r_duty);
    end
  end

  assign o_at_max      = w_at_max;
  assign o_sample_tick = r_tick;
  assign o_duty        = r_duty;
  assign o_pwm_out     = r_pwm;

endmodule

// File: rtl/sid_audio_out.sv
// ---------------------------------------------------------------------------
// sid_audio_out
// Mixes the three voice samples, applies master volume and a click-free mute
// ramp, and drives a single-bit PWM pin for an external RC filter.
//   clk, rst     : clock, synchronous active-high reset
//   voice0..2    : 8-bit voice samples
//   voice_en     : per-voice mix enable, bit n gates voice n
//   volume       : 4-bit master volume, 0 = silent
//   mute         : soft-mute request, sampled only at period end
//   pwm_out      : registered PWM output
//   sample_tick  : one-cycle pulse in the first clock of each PWM period
//   duty         : duty value in force for the current period
//   ramp_active  : high while the gain is ramping up or down
//   dbg_state    : current gain FSM state (debug visibility)
//
// Data path: stage 1 registers the enabled-voice sum, stage 2 registers the
// volume-scaled sum. At each period end the duty is loaded with
// (scaled * gain) >> 4 using the gain before that edge's ramp step.
// PWM_BITS must be at least 10 so that the full-scale mix (765) stays below
// the period and the pin never sits constantly high.
// ---------------------------------------------------------------------------
module sid_audio_out
  import sid_pkg::*;
#(
  parameter int PWM_BITS   = 10,
  parameter int RAMP_STEPS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [VOICE_W-1:0]  voice0,
  input  logic [VOICE_W-1:0]  voice1,
  input  logic [VOICE_W-1:0]  voice2,
  input  logic [2:0]          voice_en,
  input  logic [3:0]          volume,
  input  logic                mute,
  output logic                pwm_out,
  output logic                sample_tick,
  output logic [PWM_BITS-1:0] duty,
  output logic                ramp_active,
  output logic [1:0]          dbg_state
);

  // Full gain equals the number of ramp steps; the duty shift of 4 assumes 16.
  localparam logic [GAIN_W-1:0] GAIN_FULL = GAIN_W'(RAMP_STEPS);

  // ------------------------------------------------------------------------
  // Mixer pipeline
  // ------------------------------------------------------------------------
  logic [MIX_W-1:0] w_sum;
  logic [MIX_W-1:0] r_sum;
  logic [MIX_W-1:0] r_scaled;

  always_comb begin
    w_sum = '0;
    if (voice_en[0]) w_sum = w_sum + MIX_W'(voice0);
    if (voice_en[1]) w_sum = w_sum + MIX_W'(voice1);
    if (voice_en[2]) w_sum = w_sum + MIX_W'(voice2);
  end

  // Both stages run every cycle, so a volume change is picked up by whichever
  // period end comes next, with no ramp applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum    <= '0;
      r_scaled <= '0;
    end else begin
      r_sum    <= w_sum;
      r_scaled <= apply_volume(r_sum, volume);
    end
  end

  // ------------------------------------------------------------------------
  // Gain ramp FSM, stepped only at period end
  // ------------------------------------------------------------------------
  gain_state_t       r_state;
  logic [GAIN_W-1:0] r_gain;
  logic              r_ramp_active;
  logic [GAIN_W-1:0] w_gain_inc;
  logic [GAIN_W-1:0] w_gain_dec;
  logic              w_at_max;

  // Saturating neighbours of the current gain; the gain never wraps.
  assign w_gain_inc = (r_gain >= GAIN_FULL) ? GAIN_FULL : r_gain + GAIN_W'(1);
  assign w_gain_dec = (r_gain == '0) ? '0 : r_gain - GAIN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= MUTED;
      r_gain        <= '0;
      r_ramp_active <= 1'b0;
    end else if (w_at_max) begin
      case (r_state)
        MUTED: begin
          if (!mute) begin
            r_state       <= RAMP_UP;
            r_ramp_active <= 1'b1;
          end
        end
        RAMP_UP: begin
          // A mute request reverses the ramp from the current gain.
          if (mute) begin
            r_gain        <= w_gain_dec;
            r_state       <= RAMP_DOWN;
            r_ramp_active <= 1'b1;
          end else begin
            r_gain <= w_gain_inc;
            if (w_gain_inc == GAIN_FULL) begin
              r_state       <= ACTIVE;
              r_ramp_active <= 1'b0;
            end
          end
        end
        ACTIVE: begin
          if (mute) begin
            r_gain        <= GAIN_FULL - GAIN_W'(1);
            r_state       <= RAMP_DOWN;
            r_ramp_active <= 1'b1;
          end
        end
        RAMP_DOWN: begin
          // Releasing mute mid-ramp climbs back from the current gain.
          if (!mute) begin
            r_gain        <= w_gain_inc;
            r_state       <= RAMP_UP;
            r_ramp_active <= 1'b1;
          end else begin
            r_gain <= w_gain_dec;
            if (w_gain_dec == '0) begin
              r_state       <= MUTED;
              r_ramp_active <= 1'b0;
            end
          end
        end
        default: begin
          r_state       <= MUTED;
          r_gain        <= '0;
          r_ramp_active <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Duty computation and PWM modulator
  // ------------------------------------------------------------------------
  logic [PROD_W-1:0]   w_duty_prod;
  logic [PWM_BITS-1:0] w_duty_next;

  // Uses the gain before this edge's ramp step; max 765*16 >> 4 = 765.
  assign w_duty_prod = PROD_W'(r_scaled) * PROD_W'(r_gain);
  assign w_duty_next = PWM_BITS'(w_duty_prod >> 4);

  sid_pwm_mod #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk           (clk),
    .rst           (rst),
    .i_duty_next   (w_duty_next),
    .o_at_max      (w_at_max),
    .o_sample_tick (sample_tick),
    .o_duty        (duty),
    .o_pwm_out     (pwm_out)
  );

  assign ramp_active = r_ramp_active;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_sid_audio_out.sv
module tb_sid_audio_out;
  import sid_pkg::*;

  localparam int PERIOD   = 1024;
  localparam int MD_MUTED = 0;
  localparam int MD_UP    = 1;
  localparam int MD_FULL  = 2;
  localparam int MD_DOWN  = 3;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] voice0, voice1, voice2;
  logic [2:0] voice_en;
  logic [3:0] volume;
  logic       mute;
  logic       pwm_out, sample_tick, ramp_active;
  logic [9:0] duty;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  sid_audio_out #(.PWM_BITS(10), .RAMP_STEPS(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .voice0      (voice0),
    .voice1      (voice1),
    .voice2      (voice2),
    .voice_en    (voice_en),
    .volume      (volume),
    .mute        (mute),
    .pwm_out     (pwm_out),
    .sample_tick (sample_tick),
    .duty        (duty),
    .ramp_active (ramp_active),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard / counters ----------------
  int n_vec  = 0;
  int n_fail = 0;
  int g_last_hi;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Gain in sixteenths and ramp mode; duty is the level for the period.
  int m_gain, m_mode, m_duty;

  task automatic model_reset();
    m_gain = 0;
    m_mode = MD_MUTED;
    m_duty = 0;
  endtask

  function automatic int mix_level();
    int s;
    s = 0;
    if (voice_en[0]) s += voice0;
    if (voice_en[1]) s += voice1;
    if (voice_en[2]) s += voice2;
    if (volume == 0) return 0;
    return (s * (volume + 1)) / 16;
  endfunction

  task automatic model_tick();
    m_duty = (mix_level() * m_gain) / 16;
    case (m_mode)
      MD_MUTED: if (!mute) m_mode = MD_UP;
      MD_UP: begin
        if (mute) begin
          m_gain = (m_gain > 0) ? m_gain - 1 : 0;
          m_mode = MD_DOWN;
        end else begin
          m_gain = (m_gain < 16) ? m_gain + 1 : 16;
          if (m_gain == 16) m_mode = MD_FULL;
        end
      end
      MD_FULL: if (mute) begin
        m_gain = 15;
        m_mode = MD_DOWN;
      end
      default: begin
        if (!mute) begin
          m_gain = (m_gain < 16) ? m_gain + 1 : 16;
          m_mode = MD_UP;
        end else begin
          m_gain = (m_gain > 0) ? m_gain - 1 : 0;
          if (m_gain == 0) m_mode = MD_MUTED;
        end
      end
    endcase
  endtask

  // ---------------- driver: run to the next period start ----------------
  // Counts pwm highs over the elapsed period, optionally flips mute for one
  // clock at cycle glitch_at, and checks the new period against the model.
  task automatic wait_tick(input int glitch_at, input string tag);
    int  cyc;
    int  hi;
    bit  seen;
    cyc  = 0;
    hi   = 0;
    seen = 1'b0;
    while (!seen && cyc < PERIOD + 50) begin
      @(negedge clk);
      cyc++;
      if (glitch_at > 0 && cyc == glitch_at)     mute = ~mute;
      if (glitch_at > 0 && cyc == glitch_at + 1) mute = ~mute;
      if (pwm_out) hi++;
      if (sample_tick) seen = 1'b1;
    end
    g_last_hi = hi;
    if (!seen) begin
      check({tag, "_tick_timeout"}, cyc, PERIOD);
    end else begin
      check({tag, "_period_len"}, cyc, PERIOD);
      check({tag, "_pwm_high"}, hi, m_duty);
      model_tick();
      check({tag, "_duty"}, duty, m_duty);
      check({tag, "_ramp"}, ramp_active, (m_mode == MD_UP || m_mode == MD_DOWN) ? 1 : 0);
    end
  endtask

  task automatic set_voices(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [2:0] en, input logic [3:0] vol);
    voice0   = a;
    voice1   = b;
    voice2   = c;
    voice_en = en;
    volume   = vol;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] v0, v1, v2;
    logic [2:0] en;
    logic [3:0] vol;
    bit         glitch;
    int         exp_duty;
  } vec_t;

  vec_t tbl[7];

  // ---------------- watchdog ----------------
  initial begin
    #(1_500_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int ra_hi;

    // All in ACTIVE at gain 16, so duty = mix level.
    tbl[0] = '{8'd128, 8'd0,   8'd0,   3'b001, 4'd7,  1'b0, 64};
    tbl[1] = '{8'd128, 8'd0,   8'd0,   3'b001, 4'd0,  1'b0, 0};
    tbl[2] = '{8'd100, 8'd50,  8'd25,  3'b101, 4'd15, 1'b1, 125};
    tbl[3] = '{8'd255, 8'd255, 8'd255, 3'b110, 4'd3,  1'b0, 127};
    tbl[4] = '{8'd10,  8'd20,  8'd30,  3'b111, 4'd15, 1'b0, 60};
    tbl[5] = '{8'd255, 8'd0,   8'd255, 3'b111, 4'd9,  1'b0, 318};
    tbl[6] = '{8'd200, 8'd200, 8'd0,   3'b011, 4'd15, 1'b0, 400};

    // Power-on reset with full-scale inputs.
    rst = 1'b1;
    set_voices(8'd255, 8'd255, 8'd255, 3'b111, 4'd15);
    mute = 1'b0;
    repeat (3) @(negedge clk);
    check("por_pwm", pwm_out, 0);
    check("por_duty", duty, 0);
    check("por_tick", sample_tick, 0);
    rst = 1'b0;
    model_reset();

    // Run into the ramp so there is live state to discard.
    for (int i = 0; i < 3; i++) wait_tick(0, "pre");
    check("pre_duty", duty, 47);
    repeat (20) @(negedge clk);
    check("pre_pwm_high", pwm_out, 1);
    check("pre_ramp", ramp_active, 1);

    // Mid-period reset for 3 cycles.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm_out, 0);
    check("rst_duty", duty, 0);
    check("rst_tick", sample_tick, 0);
    check("rst_ramp", ramp_active, 0);
    check("rst_state", dbg_state, MUTED);
    rst = 1'b0;
    model_reset();

    // Full-scale ramp-up; first tick must land 1024 clocks after release.
    ra_hi = 0;
    for (int i = 0; i < 18; i++) begin
      wait_tick(0, "rampup");
      if (ramp_active) ra_hi++;
    end
    check("rampup_ticks_active", ra_hi, 16);
    check("rampup_done_ramp", ramp_active, 0);
    check("rampup_state", dbg_state, ACTIVE);
    check("rampup_final_duty", duty, 765);
    wait_tick(0, "full");
    check("full_pwm_high_count", g_last_hi, 765);

    // Table of mix / volume / enable vectors in ACTIVE.
    for (int i = 0; i < 7; i++) begin
      set_voices(tbl[i].v0, tbl[i].v1, tbl[i].v2, tbl[i].en, tbl[i].vol);
      wait_tick(tbl[i].glitch ? 400 : 0, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_duty", i), duty, tbl[i].exp_duty);
      check($sformatf("tbl%0d_ramp", i), ramp_active, 0);
      check($sformatf("tbl%0d_state", i), dbg_state, ACTIVE);
    end

    // Ramp down 8 steps from sum 400, then release mute.
    mute = 1'b1;
    for (int i = 0; i < 8; i++) wait_tick(0, "down");
    check("down8_duty", duty, 225);
    mute = 1'b0;
    wait_tick(0, "rev");
    check("rev_duty", duty, 200);
    check("rev_ramp", ramp_active, 1);
    for (int i = 0; i < 7; i++) wait_tick(0, "reup");
    check("reup_ramp", ramp_active, 0);
    check("reup_state", dbg_state, ACTIVE);
    wait_tick(0, "reup_full");
    check("reup_duty", duty, 400);

    // Full mute held.
    mute = 1'b1;
    for (int i = 0; i < 16; i++) wait_tick(0, "mute");
    check("mute_state", dbg_state, MUTED);
    check("mute_ramp", ramp_active, 0);
    wait_tick(0, "muted");
    check("muted_duty", duty, 0);
    wait_tick(0, "muted_pwm");
    check("muted_pwm_high_count", g_last_hi, 0);

    // Randomised periods against the model, with mid-period mute glitches.
    for (int r = 0; r < 10; r++) begin
      set_voices(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)));
      mute = ($urandom_range(0, 2) == 0);
      wait_tick(($urandom_range(0, 1) == 1) ? 300 : 0, $sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
